fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one sync_fifo write port between NUM_REQ producers.
- Each producer presents a valid/ready stream.
- The arbiter grants one producer at a time for a bounded burst and drives the FIFO's wr_en/data_in.
- It honours the FIFO's full flag so that no write is ever lost or dropped.
- It sits directly in front of sync_fifo. The FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 20 ++
 rtl/fifo_wr_arbiter.sv | 76 +++++++
 tb/tb_fifo_wr_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type, default sizing and helpers for the
// round-robin FIFO write arbiter.
package fifo_arb_pkg;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 4;

    typedef enum logic {IDLE, BURST} arb_state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder; picks the first
// requester strictly after last_grant, wrapping modulo NUM_REQ.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [IW-1:0]      winner,
    output logic               any_req
);
    // Scan farthest-first so the nearest set bit after last_grant overwrites.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ; i >= 1; i--)
            if (req[(int'(last_grant) + i) % NUM_REQ]) winner = IW'((int'(last_grant) + i) % NUM_REQ);
    end

    assign any_req = |req;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one sync_fifo write port between NUM_REQ
// valid/ready producers using bounded round-robin bursts.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      grant_valid,
    output logic [clog2(NUM_REQ)-1:0] grant_id
);
    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(BURST_MAX + 1);

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] winner;
    logic [CW-1:0] beat_cnt;
    logic          any_req;
    logic          in_burst;
    logic          cur_valid;
    logic          accept;
    logic          done;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // Write path is combinational so a valid beat reaches the FIFO in the same cycle.
    always_comb begin
        in_burst     = state == BURST;
        cur_valid    = req_valid[grant_id];
        accept       = in_burst & cur_valid & ~fifo_full;
        fifo_wr_en   = accept;
        fifo_data_in = accept ? req_data[grant_id*DATA_W +: DATA_W] : '0;
        req_ready    = (in_burst & ~fifo_full) ? NUM_REQ'(1) << grant_id : '0;
        done         = (accept && beat_cnt == CW'(BURST_MAX - 1))
                     || (!cur_valid && !fifo_full)
                     || (!arb_en && !accept);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            beat_cnt    <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
        end else if (state == IDLE) begin
            if (arb_en && any_req) begin
                state       <= BURST;
                grant_valid <= 1'b1;
                grant_id    <= winner;
                beat_cnt    <= '0;
            end
        end else if (done) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
            last_grant  <= grant_id;
        end else if (accept) begin
            beat_cnt    <= beat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized bench; a per-cycle reference
// model queues expected outputs, a monitor pops and compares them.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int BM = 4;

    typedef struct {
        logic [N-1:0]  rdy;
        logic          wr;
        logic [DW-1:0] d;
        logic          gv;
        int            gid;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arb_en = 1'b0;
    logic            fifo_full = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic            grant_valid;
    logic [1:0]      grant_id;

    logic [DW-1:0] nxt [N];
    logic [N-1:0]  adv = '0;
    exp_t          q[$];
    int            gq[$];
    int            ex[$];
    int            checks = 0;
    int            errors = 0;
    int            nwr = 0;
    int            n0;
    bit            gv_prev = 0;
    bit            rnd = 0;
    int            owner = -1;
    int            left = 0;
    int            last = N - 1;

    fifo_wr_arbiter #(.DATA_W(DW), .NUM_REQ(N), .BURST_MAX(BM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    always_comb for (int i = 0; i < N; i++) req_data[i*DW +: DW] = nxt[i];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_order(input string nm, input int exp_q[$]);
        chk({nm, "_count"}, 32'(gq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk(nm, 32'(i < gq.size() ? gq[i] : -1), 32'(exp_q[i]));
    endtask

    // Reference: one owner at a time, BM beats allowed per grant, pointer moves past the owner.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        e.rdy = '0; e.wr = 1'b0; e.d = '0; e.gv = 1'b0; e.gid = 0;
        adv = '0;
        if (!rst_n) begin
            owner = -1;
            left  = 0;
            last  = N - 1;
        end else if (owner < 0) begin
            if (arb_en)
                for (int k = 1; k <= N; k++)
                    if (owner < 0 && req_valid[(last + k) % N]) owner = (last + k) % N;
            left = BM;
        end else begin
            acc   = req_valid[owner] && !fifo_full;
            e.gv  = 1'b1;
            e.gid = owner;
            e.rdy = fifo_full ? '0 : N'(1 << owner);
            e.wr  = acc;
            e.d   = acc ? nxt[owner] : '0;
            adv[owner] = acc;
            if (acc) left--;
            if (left == 0 || (!req_valid[owner] && !fifo_full) || (!arb_en && !acc)) begin
                last  = owner;
                owner = -1;
            end
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL model_queue empty at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e.wr));
            chk("fifo_data_in", 32'(fifo_data_in), 32'(e.d));
            chk("req_ready", 32'(req_ready), 32'(e.rdy));
            chk("grant_valid", 32'(grant_valid), 32'(e.gv));
            if (e.gv) chk("grant_id", 32'(grant_id), 32'(e.gid));
        end
        if (fifo_wr_en) nwr++;
        if (grant_valid && !gv_prev) gq.push_back(int'(grant_id));
        gv_prev = grant_valid;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (adv[i]) nxt[i] = nxt[i] + 1'b1;
            if (rnd) begin
                for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) req_valid[i] = ~req_valid[i];
                fifo_full = $urandom_range(3) == 0;
                arb_en    = $urandom_range(9) != 0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; arb_en = 1'b0; req_valid = '0; fifo_full = 1'b0; rnd = 0;
        cyc(2);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_fifo_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_fifo_data_in", 32'(fifo_data_in), 0);
        rst_n = 1'b1;
        gq.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) nxt[i] = DW'(16 * i);
        do_reset();

        nxt[0] = 8'h10; arb_en = 1'b1; req_valid = 4'b0001; n0 = nwr;
        cyc(10);
        chk("s1_writes", 32'(nwr - n0), 8);
        chk("s1_next_data", 32'(nxt[0]), 32'h18);
        ex = '{0, 0}; chk_order("s1_order", ex);

        do_reset();
        req_valid = 4'b1111; arb_en = 1'b1;
        cyc(24);
        ex = '{0, 1, 2, 3, 0}; chk_order("s2_order", ex);

        do_reset();
        req_valid = 4'b1100; arb_en = 1'b1;
        cyc(3);
        fifo_full = 1'b1; n0 = nwr;
        cyc(3);
        chk("s3_no_write_full", 32'(nwr - n0), 0);
        fifo_full = 1'b0;
        cyc(6);
        ex = '{2, 3}; chk_order("s3_order", ex);

        do_reset();
        req_valid = 4'b0011; arb_en = 1'b1;
        cyc(7);
        req_valid = 4'b0101;
        cyc(6);
        ex = '{0, 1, 2}; chk_order("s4_order", ex);

        do_reset();
        arb_en = 1'b1; req_valid = 4'b0001;
        cyc(1);
        arb_en = 1'b0; req_valid = 4'b1111;
        cyc(8);
        n0 = nwr;
        cyc(4);
        chk("s5_no_write", 32'(nwr - n0), 0);
        chk("s5_idle", 32'(grant_valid), 0);
        arb_en = 1'b1;
        cyc(3);
        ex = '{0, 1}; chk_order("s5_resume", ex);

        do_reset();
        req_valid = 4'b1000; arb_en = 1'b1;
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_async_wr_en", 32'(fifo_wr_en), 0);
        chk("s6_async_grant", 32'(grant_valid), 0);
        chk("s6_async_ready", 32'(req_ready), 0);
        do_reset();
        req_valid = 4'b1111; arb_en = 1'b1;
        cyc(3);
        ex = '{0}; chk_order("s6_first_grant", ex);

        do_reset();
        rnd = 1; arb_en = 1'b1; n0 = nwr;
        cyc(400);
        rnd = 0;
        chk("rand_progress", 32'(nwr > n0), 1);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
